// File: rtl/traffic_pkg.sv
// Shared phase encoding, default timing and side-index width for the intersection sequencer.
// Constants only: no latency, no backpressure.
package traffic_pkg;

    localparam int SIDE_W = 2;

    localparam logic [1:0] PH_ALLRED = 2'd0;
    localparam logic [1:0] PH_GREEN  = 2'd1;
    localparam logic [1:0] PH_ORANGE = 2'd2;

    localparam int DEF_GREEN_BUSY = 30;
    localparam int DEF_GREEN_IDLE = 10;
    localparam int DEF_GAP_T      = 5;
    localparam int DEF_ORANGE_T   = 3;
    localparam int DEF_ALLRED_T   = 1;

    function automatic logic [3:0] side_mask(input logic [SIDE_W-1:0] side);
        side_mask = 4'b0001 << side;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational 4-way round-robin picker: first request after 'last', wrapping back to 'last'.
// Latency: 0 (pure logic); no backpressure.
module rr_pick
    import traffic_pkg::*;
(
    input  logic [3:0]        req,
    input  logic [SIDE_W-1:0] last,
    output logic [SIDE_W-1:0] grant,
    output logic              any
);

    logic [SIDE_W-1:0] idx;

    // Walk from the farthest candidate to the nearest so the nearest request wins.
    always_comb begin
        grant = last + 2'd1;
        idx   = '0;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (req[idx]) begin
                grant = idx;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/phase_scheduler.sv
// Density-aware round-robin phase sequencer with gap-out and emergency override, stepped by a 1 Hz TICK.
// Latency: all outputs registered, 1 clk from inputs; no backpressure.
module phase_scheduler
    import traffic_pkg::*;
#(
    parameter int GREEN_BUSY = DEF_GREEN_BUSY,
    parameter int GREEN_IDLE = DEF_GREEN_IDLE,
    parameter int GAP_T      = DEF_GAP_T,
    parameter int ORANGE_T   = DEF_ORANGE_T,
    parameter int ALLRED_T   = DEF_ALLRED_T
) (
    input  logic              CLK_100MHZ,
    input  logic              RESET,
    input  logic              TICK,
    input  logic [3:0]        T,
    input  logic              EMG,
    input  logic [SIDE_W-1:0] EMG_SIDE,
    output logic [SIDE_W-1:0] SIDE,
    output logic [1:0]        PHASE,
    output logic [3:0]        RED,
    output logic [3:0]        GREEN,
    output logic [3:0]        ORANGE,
    output logic [5:0]        REMAIN,
    output logic              NEXT
);

    localparam logic [5:0] GB_R = 6'(GREEN_BUSY);
    localparam logic [5:0] GI_R = 6'(GREEN_IDLE);
    localparam logic [5:0] GP_R = 6'(GAP_T);
    localparam logic [5:0] OT_R = 6'(ORANGE_T);
    localparam logic [5:0] AT_R = 6'(ALLRED_T);

    logic [1:0]        state_q,  state_d;
    logic [SIDE_W-1:0] side_q,   side_d;
    logic [5:0]        remain_q, remain_d;
    logic [3:0]        red_q,    red_d;
    logic [3:0]        green_q,  green_d;
    logic [3:0]        orange_q, orange_d;
    logic              next_q,   next_d;

    logic [SIDE_W-1:0] rr_grant;
    logic              rr_any;
    logic [SIDE_W-1:0] pick_side;
    logic              in_green;
    logic              emg_preempt;
    logic              emg_hold;
    logic              expire;
    logic              gap_out;
    logic [3:0]        mask_d;

    rr_pick u_rr_pick (
        .req   (T),
        .last  (side_q),
        .grant (rr_grant),
        .any   (rr_any)
    );

    assign in_green    = (state_q == PH_GREEN);
    assign emg_preempt = in_green && EMG && (EMG_SIDE != side_q);
    assign emg_hold    = in_green && EMG && (EMG_SIDE == side_q);
    assign expire      = TICK && (remain_q == 6'd1);
    assign gap_out     = in_green && !T[side_q]
                         && ((T & ~side_mask(side_q)) != 4'b0000)
                         && (remain_q > GP_R);
    assign pick_side   = EMG ? EMG_SIDE : (rr_any ? rr_grant : side_q + 2'd1);

    always_comb begin
        state_d  = state_q;
        side_d   = side_q;
        remain_d = remain_q;
        next_d   = 1'b0;
        if (emg_preempt) begin
            state_d  = PH_ORANGE;
            remain_d = OT_R;
        end else if (emg_hold) begin
            remain_d = remain_q;
        end else if (expire) begin
            case (state_q)
                PH_ALLRED: begin
                    state_d  = PH_GREEN;
                    side_d   = pick_side;
                    remain_d = T[pick_side] ? GB_R : GI_R;
                    next_d   = 1'b1;
                end
                PH_GREEN: begin
                    state_d  = PH_ORANGE;
                    remain_d = OT_R;
                end
                default: begin
                    state_d  = PH_ALLRED;
                    remain_d = AT_R;
                end
            endcase
        end else if (gap_out) begin
            remain_d = GP_R;
        end else if (TICK) begin
            remain_d = remain_q - 6'd1;
        end
    end

    // Lamps decode from the next state so they switch on the same edge as the phase.
    always_comb begin
        mask_d   = side_mask(side_d);
        red_d    = (state_d == PH_ALLRED) ? 4'b1111 : ~mask_d;
        green_d  = (state_d == PH_GREEN)  ? mask_d  : 4'b0000;
        orange_d = (state_d == PH_ORANGE) ? mask_d  : 4'b0000;
    end

    always_ff @(posedge CLK_100MHZ) begin
        if (RESET) begin
            state_q  <= PH_ALLRED;
            side_q   <= 2'd3;
            remain_q <= AT_R;
            red_q    <= 4'b1111;
            green_q  <= 4'b0000;
            orange_q <= 4'b0000;
            next_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            side_q   <= side_d;
            remain_q <= remain_d;
            red_q    <= red_d;
            green_q  <= green_d;
            orange_q <= orange_d;
            next_q   <= next_d;
        end
    end

    assign SIDE   = side_q;
    assign PHASE  = state_q;
    assign RED    = red_q;
    assign GREEN  = green_q;
    assign ORANGE = orange_q;
    assign REMAIN = remain_q;
    assign NEXT   = next_q;

endmodule

// File: tb/tb_phase_scheduler.sv
// Bench for phase_scheduler: directed scenarios plus randomized traffic against a spec-level model.
module tb_phase_scheduler;

    localparam int GB  = 30;
    localparam int GI  = 10;
    localparam int GAP = 5;
    localparam int OT  = 3;
    localparam int AT  = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic [3:0] t = 4'b0000;
    logic       emg = 1'b0;
    logic [1:0] emg_side = 2'd0;
    logic [1:0] side_o;
    logic [1:0] phase_o;
    logic [3:0] red_o;
    logic [3:0] green_o;
    logic [3:0] orange_o;
    logic [5:0] remain_o;
    logic       next_o;

    int checks = 0;
    int errors = 0;

    // Reference model state: phase 0/1/2, owning side, seconds left, new-green pulse.
    int m_ph   = 0;
    int m_side = 3;
    int m_rem  = AT;
    bit m_next = 1'b0;

    always #5 clk = ~clk;

    phase_scheduler dut (
        .CLK_100MHZ (clk),
        .RESET      (reset),
        .TICK       (tick),
        .T          (t),
        .EMG        (emg),
        .EMG_SIDE   (emg_side),
        .SIDE       (side_o),
        .PHASE      (phase_o),
        .RED        (red_o),
        .GREEN      (green_o),
        .ORANGE     (orange_o),
        .REMAIN     (remain_o),
        .NEXT       (next_o)
    );

    task automatic model_step();
        int  nph  = m_ph;
        int  ns   = m_side;
        int  nr   = m_rem;
        bit  nn   = 1'b0;
        int  p;
        bit  found;
        bit  others;
        others = 1'b0;
        for (int i = 0; i < 4; i++) if (i != m_side && t[i]) others = 1'b1;
        if (reset) begin
            nph = 0; ns = 3; nr = AT;
        end else if (m_ph == 1 && emg && int'(emg_side) != m_side) begin
            nph = 2; nr = OT;
        end else if (m_ph == 1 && emg) begin
            nr = m_rem;
        end else if (tick && m_rem == 1) begin
            if (m_ph == 0) begin
                if (emg) begin
                    p = int'(emg_side);
                end else begin
                    p = (m_side + 1) % 4;
                    found = 1'b0;
                    for (int k = 1; k <= 4; k++) begin
                        if (!found && t[(m_side + k) % 4]) begin
                            p = (m_side + k) % 4;
                            found = 1'b1;
                        end
                    end
                end
                nph = 1; ns = p; nr = t[p] ? GB : GI; nn = 1'b1;
            end else if (m_ph == 1) begin
                nph = 2; nr = OT;
            end else begin
                nph = 0; nr = AT;
            end
        end else if (m_ph == 1 && !t[m_side] && others && m_rem > GAP) begin
            nr = GAP;
        end else if (tick) begin
            nr = m_rem - 1;
        end
        m_ph = nph; m_side = ns; m_rem = nr; m_next = nn;
    endtask

    task automatic cyc(input bit tk);
        tick = tk;
        model_step();
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; t = 4'b0000; emg = 1'b0; emg_side = 2'd0;
        cyc(1'b0);
        cyc(1'b0);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({phase_o, side_o, remain_o} !== {2'd0, 2'd3, 6'd1}) begin
            errors++;
            $display("FAIL reset_state phase=%0d side=%0d remain=%0d expected 0/3/1", phase_o, side_o, remain_o);
        end
        checks++;
        if ({red_o, green_o, orange_o, next_o} !== {4'hF, 4'h0, 4'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_lamps red=%b green=%b orange=%b next=%b expected 1111/0000/0000/0", red_o, green_o, orange_o, next_o);
        end
    endtask

    task automatic test_idle_pick();
        bit got;
        do_reset();
        t = 4'b0000;
        cyc(1'b1);
        checks++;
        if ({phase_o, side_o, green_o, remain_o, next_o} !== {2'd1, 2'd0, 4'b0001, 6'd10, 1'b1}) begin
            errors++;
            $display("FAIL idle_first_green phase=%0d side=%0d green=%b remain=%0d next=%b expected 1/0/0001/10/1",
                     phase_o, side_o, green_o, remain_o, next_o);
        end
        cyc(1'b0);
        checks++;
        if (next_o !== 1'b0) begin
            errors++;
            $display("FAIL next_one_cycle next=%b expected 0", next_o);
        end
        got = 1'b0;
        for (int c = 0; c < 500 && !got; c++) begin
            cyc(1'b1);
            if (next_o === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got || side_o !== 2'd1 || remain_o !== 6'd10) begin
            errors++;
            $display("FAIL idle_second_green got=%0d side=%0d remain=%0d expected 1/1/10", got, side_o, remain_o);
        end
    endtask

    task automatic test_alternate();
        int seen = 0;
        int bad  = 0;
        int exp_seq [4] = '{1, 3, 1, 3};
        do_reset();
        t = 4'b1010;
        for (int c = 0; c < 4000 && seen < 4; c++) begin
            cyc(c % 2 == 0);
            if (green_o[0] === 1'b1 || green_o[2] === 1'b1) bad++;
            if (next_o === 1'b1) begin
                checks++;
                if (side_o !== 2'(exp_seq[seen]) || remain_o !== 6'd30) begin
                    errors++;
                    $display("FAIL alternate_green%0d side=%0d remain=%0d expected %0d/30", seen, side_o, remain_o, exp_seq[seen]);
                end
                seen++;
            end
        end
        checks++;
        if (seen != 4) begin
            errors++;
            $display("FAIL alternate_timeout greens=%0d expected 4", seen);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL alternate_idle_sides cycles_green_0_or_2=%0d expected 0", bad);
        end
    endtask

    task automatic test_gapout();
        do_reset();
        t = 4'b0010;
        cyc(1'b1);
        for (int i = 0; i < 10; i++) cyc(1'b1);
        checks++;
        if ({phase_o, side_o, remain_o} !== {2'd1, 2'd1, 6'd20}) begin
            errors++;
            $display("FAIL gap_setup phase=%0d side=%0d remain=%0d expected 1/1/20", phase_o, side_o, remain_o);
        end
        t = 4'b0100;
        cyc(1'b0);
        checks++;
        if (remain_o !== 6'd5) begin
            errors++;
            $display("FAIL gap_clamp remain=%0d expected 5", remain_o);
        end
        for (int i = 0; i < 5; i++) cyc(1'b1);
        checks++;
        if ({phase_o, orange_o, remain_o} !== {2'd2, 4'b0010, 6'd3}) begin
            errors++;
            $display("FAIL gap_orange phase=%0d orange=%b remain=%0d expected 2/0010/3", phase_o, orange_o, remain_o);
        end
        for (int i = 0; i < 3; i++) cyc(1'b1);
        checks++;
        if ({phase_o, red_o, remain_o} !== {2'd0, 4'b1111, 6'd1}) begin
            errors++;
            $display("FAIL gap_allred phase=%0d red=%b remain=%0d expected 0/1111/1", phase_o, red_o, remain_o);
        end
        cyc(1'b1);
        checks++;
        if ({phase_o, side_o, remain_o} !== {2'd1, 2'd2, 6'd30}) begin
            errors++;
            $display("FAIL gap_next_green phase=%0d side=%0d remain=%0d expected 1/2/30", phase_o, side_o, remain_o);
        end
    endtask

    task automatic test_emergency();
        do_reset();
        t = 4'b0001;
        cyc(1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b1);
        emg = 1'b1; emg_side = 2'd2;
        cyc(1'b0);
        checks++;
        if ({phase_o, side_o, orange_o, remain_o} !== {2'd2, 2'd0, 4'b0001, 6'd3}) begin
            errors++;
            $display("FAIL emg_preempt phase=%0d side=%0d orange=%b remain=%0d expected 2/0/0001/3",
                     phase_o, side_o, orange_o, remain_o);
        end
        for (int i = 0; i < 4; i++) cyc(1'b1);
        checks++;
        if ({phase_o, side_o, remain_o} !== {2'd1, 2'd2, 6'd10}) begin
            errors++;
            $display("FAIL emg_green phase=%0d side=%0d remain=%0d expected 1/2/10", phase_o, side_o, remain_o);
        end
        for (int i = 0; i < 12; i++) cyc(1'b1);
        checks++;
        if ({phase_o, remain_o} !== {2'd1, 6'd10}) begin
            errors++;
            $display("FAIL emg_hold phase=%0d remain=%0d expected 1/10", phase_o, remain_o);
        end
        emg = 1'b0;
        cyc(1'b0);
        checks++;
        if (remain_o !== 6'd5) begin
            errors++;
            $display("FAIL emg_release_gap remain=%0d expected 5", remain_o);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        t = 4'b1000;
        cyc(1'b1);
        emg = 1'b1; emg_side = 2'd0;
        cyc(1'b0);
        emg = 1'b0;
        checks++;
        if ({phase_o, side_o, orange_o} !== {2'd2, 2'd3, 4'b1000}) begin
            errors++;
            $display("FAIL mid_setup phase=%0d side=%0d orange=%b expected 2/3/1000", phase_o, side_o, orange_o);
        end
        reset = 1'b1;
        cyc(1'b1);
        reset = 1'b0;
        checks++;
        if ({red_o, orange_o, phase_o, remain_o, side_o} !== {4'b1111, 4'b0000, 2'd0, 6'd1, 2'd3}) begin
            errors++;
            $display("FAIL mid_reset red=%b orange=%b phase=%0d remain=%0d side=%0d expected 1111/0000/0/1/3",
                     red_o, orange_o, phase_o, remain_o, side_o);
        end
    endtask

    task automatic test_tick_gap();
        do_reset();
        t = 4'b0010;
        cyc(1'b1);
        for (int i = 0; i < 29; i++) cyc(1'b1);
        checks++;
        if ({phase_o, remain_o} !== {2'd1, 6'd1}) begin
            errors++;
            $display("FAIL tg_setup phase=%0d remain=%0d expected 1/1", phase_o, remain_o);
        end
        t = 4'b0100;
        cyc(1'b1);
        checks++;
        if ({phase_o, remain_o} !== {2'd2, 6'd3}) begin
            errors++;
            $display("FAIL tg_expiry_wins phase=%0d remain=%0d expected 2/3", phase_o, remain_o);
        end
    endtask

    task automatic test_random();
        logic [3:0] e_mask;
        logic [3:0] e_red, e_grn, e_org;
        do_reset();
        for (int c = 0; c < 5000; c++) begin
            if ($urandom_range(0, 19) == 0) t = 4'($urandom);
            if ($urandom_range(0, 149) == 0) begin
                emg = ~emg;
                emg_side = 2'($urandom);
            end
            reset = ($urandom_range(0, 1999) == 0);
            cyc($urandom_range(0, 2) == 0);
            e_mask = 4'b0001 << m_side;
            e_red  = (m_ph == 0) ? 4'b1111 : ~e_mask;
            e_grn  = (m_ph == 1) ? e_mask : 4'b0000;
            e_org  = (m_ph == 2) ? e_mask : 4'b0000;
            checks++;
            if ({phase_o, side_o, remain_o, next_o, red_o, green_o, orange_o} !==
                {2'(m_ph), 2'(m_side), 6'(m_rem), m_next, e_red, e_grn, e_org}) begin
                errors++;
                $display("FAIL random_c%0d ph=%0d side=%0d rem=%0d next=%b r/g/o=%b/%b/%b expected %0d/%0d/%0d/%b %b/%b/%b",
                         c, phase_o, side_o, remain_o, next_o, red_o, green_o, orange_o,
                         m_ph, m_side, m_rem, m_next, e_red, e_grn, e_org);
            end
        end
        reset = 1'b0; emg = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle_pick();
        test_alternate();
        test_gapout();
        test_emergency();
        test_reset_mid();
        test_tick_gap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/phase_scheduler.md
# phase_scheduler

Density-aware phase sequencer for the four-way intersection. It decides which side gets green next and for how long, and drives the per-side RED/GREEN/ORANGE lamps plus a seconds countdown for the display path. Arbitration is round-robin over sides with traffic (T1..T4 switches), with gap-out and an emergency override. It runs on the board clock and advances on a 1 Hz enable pulse from the tick generator.

## Interface
- GREEN_BUSY, 30: green seconds for a side with traffic
- GREEN_IDLE, 10: green seconds when the selected side has no traffic
- GAP_T, 5: clamp applied to remaining green when its own side empties and another side waits
- ORANGE_T, 3: orange seconds
- ALLRED_T, 1: all-red clearance seconds
- All parameters are in the range 1..63. GAP_T is at most GREEN_IDLE.

- CLK_100MHZ, in, 1: system clock.
- RESET, in, 1: synchronous, active-high.
- TICK, in, 1: one-cycle 1 Hz enable pulse.
- T, in, 4: traffic present per side, level, bit i = side i.
- EMG, in, 1: emergency request, level.
- EMG_SIDE, in, 2: side the emergency vehicle is on.
- SIDE, out, 2: side currently owning the phase.
- PHASE, out, 2: 0 = ALLRED, 1 = GREEN, 2 = ORANGE.
- RED, out, 4: lamp per side.
- GREEN, out, 4: lamp per side.
- ORANGE, out, 4: lamp per side.
- REMAIN, out, 6: seconds left in the current phase (binary).
- NEXT, out, 1: one-cycle pulse on the edge a new green starts.

## Operation
- FSM states are ALLRED, GREEN and ORANGE. All outputs are registered.
- Reset values:
  - state ALLRED, SIDE = 3, REMAIN = ALLRED_T
  - RED = 4'b1111, GREEN = 0, ORANGE = 0, NEXT = 0
  - With SIDE = 3, the first pick searches from side 0.
- Lamps:
  - In GREEN or ORANGE, side SIDE shows that colour and all other sides are red.
  - In ALLRED, all four sides are red.
  - Exactly one lamp per side is lit in every cycle.
- Countdown: on TICK, REMAIN decrements. A phase ends on the TICK at which REMAIN == 1, and the next phase is loaded on that same edge. REMAIN never shows 0.
- ALLRED to GREEN: the pick is made from T sampled on the ending edge.
  - If EMG is set, pick EMG_SIDE.
  - Otherwise pick the first side with T set, searching SIDE+1, SIDE+2, SIDE+3, SIDE (mod 4).
  - If no T bit is set, pick SIDE+1 (mod 4).
  - Load REMAIN with GREEN_BUSY if T[pick] is set, else GREEN_IDLE. Pulse NEXT.
- GREEN to ORANGE: when the countdown expires, load REMAIN = ORANGE_T.
- ORANGE to ALLRED: when the countdown expires, load REMAIN = ALLRED_T.
- Gap-out: in GREEN with T[SIDE] = 0, any other T bit set, and REMAIN > GAP_T, set REMAIN = GAP_T on the next clock. This takes effect independent of TICK.
- Emergency:
  - In GREEN with EMG set and EMG_SIDE != SIDE: go to ORANGE on the next clock with REMAIN = ORANGE_T. ORANGE and ALLRED are never shortened.
  - In GREEN with EMG set and EMG_SIDE == SIDE: hold REMAIN (ignore TICK and gap-out) until EMG drops.
- Precedence when events coincide: RESET, then emergency preempt, then emergency hold, then countdown expiry, then gap-out.
- Mid-operation RESET returns to the reset values on the next edge, regardless of state.

## Timing
- Single clock domain. TICK is assumed to be a clean one-cycle pulse in CLK_100MHZ.
- Phase length in TICKs equals the value loaded into REMAIN.
- Lamps, SIDE and PHASE change on the same edge as the state change. There is no extra pipeline stage.
- Emergency preempt latency is 1 clock from EMG rising to ORANGE.
- Gap-out latency is 1 clock.
- T, EMG and EMG_SIDE are assumed already synchronised upstream. The block adds no debouncing.
- Full steady cycle with every side busy: 4 × (GREEN_BUSY + ORANGE_T + ALLRED_T) TICKs = 136 s at the default parameters.

## Structure
- Package traffic_pkg holds:
  - the phase encoding (ALLRED/GREEN/ORANGE localparams)
  - default timing constants
  - the side index width (2)
- Sub-module rr_pick: combinational 4-way round-robin picker.
  - Inputs: req[3:0], last[1:0].
  - Outputs: grant[1:0], any.
  - Used for the ALLRED to GREEN selection.
- The top-level lamp decode stays inside phase_scheduler. It is a registered one-hot decode from state and SIDE.

## Test plan
- Reset then T = 0: ALLRED for 1 TICK. SIDE = 0, GREEN = 4'b0001, REMAIN = 10, NEXT pulses. Next green is SIDE = 1.
- T = 4'b1010 held from reset: greens alternate 1, 3, 1, 3, each REMAIN = 30. Sides 0 and 2 are never green.
- Green on side 1 with T = 4'b0010 at REMAIN = 20, then T becomes 4'b0100: the next clock shows REMAIN = 5. After ORANGE (3) and ALLRED (1), side 2 gets green with 30.
- Green on side 0 at REMAIN = 25, EMG = 1 with EMG_SIDE = 2: next clock is ORANGE on side 0 with REMAIN = 3. Then ALLRED, then side 2 green. REMAIN is frozen while EMG stays high.
- RESET asserted during ORANGE on side 3: next edge gives RED = 4'b1111, PHASE = 0, REMAIN = 1.
- TICK coinciding with gap-out at REMAIN = 1: expiry wins and the block enters ORANGE with REMAIN = 3.
